// File: rtl/disparity_scan_ctrl_if.sv
// Handshake bundle between the disparity scan controller, the SAD cost engine
// and the depth stage. master = controller side, slave = environment side.
interface disparity_scan_ctrl_if #(
    parameter int COST_W = 18,
    parameter int DISP_W = 6
);
    logic              start;
    logic [DISP_W-1:0] disp_min;
    logic [DISP_W-1:0] disp_max;
    logic              abort;
    logic              busy;

    logic              cost_req;
    logic [DISP_W-1:0] cost_disp;
    logic              cost_valid;
    logic [COST_W-1:0] cost_in;

    logic [COST_W-1:0] best_cost;
    logic [DISP_W-1:0] best_disp;
    logic              result_valid;
    logic              result_ready;
    logic              range_err;

    modport master (
        input  start, disp_min, disp_max, abort, cost_valid, cost_in, result_ready,
        output busy, cost_req, cost_disp, best_cost, best_disp, result_valid, range_err
    );

    modport slave (
        output start, disp_min, disp_max, abort, cost_valid, cost_in, result_ready,
        input  busy, cost_req, cost_disp, best_cost, best_disp, result_valid, range_err
    );
endinterface

// File: rtl/disparity_scan_ctrl.sv
// Walks a disparity range, requests one SAD cost per disparity, tracks the
// argmin and hands the winning disparity to the depth stage via valid/ready.
module disparity_scan_ctrl #(
    parameter int                COST_W   = 18,
    parameter int                DISP_W   = 6,
    parameter logic [COST_W-1:0] COST_MAX = {COST_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    disparity_scan_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic              first;
    logic [DISP_W-1:0] disp_last;
    logic              cost_req;
    logic [DISP_W-1:0] cost_disp;
    logic              busy;
    logic [COST_W-1:0] best_cost;
    logic [DISP_W-1:0] best_disp;
    logic              result_valid;
    logic              range_err;

    // Strict less-than keeps the earlier (lower) disparity on ties.
    function automatic logic take_sample(input logic              is_first,
                                         input logic [COST_W-1:0] cand,
                                         input logic [COST_W-1:0] cur);
        return is_first || (cand < cur);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            first        <= 1'b1;
            disp_last    <= '0;
            cost_req     <= 1'b0;
            cost_disp    <= '0;
            busy         <= 1'b0;
            best_cost    <= COST_MAX;
            best_disp    <= '0;
            result_valid <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        disp_last <= bus.disp_max;
                        cost_disp <= bus.disp_min;
                        busy      <= 1'b1;
                        if (bus.disp_max >= bus.disp_min) begin
                            first     <= 1'b1;
                            range_err <= 1'b0;
                            cost_req  <= 1'b1;
                            state     <= REQ;
                        end else begin
                            best_cost    <= COST_MAX;
                            best_disp    <= bus.disp_min;
                            range_err    <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                REQ: begin
                    cost_req <= 1'b0;
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.cost_valid) begin
                        if (take_sample(first, bus.cost_in, best_cost)) begin
                            best_cost <= bus.cost_in;
                            best_disp <= cost_disp;
                        end
                        first <= 1'b0;
                        // Terminate on the last disparity before incrementing, so the top code never wraps.
                        if (cost_disp == disp_last) begin
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cost_disp <= cost_disp + DISP_W'(1);
                            cost_req  <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cost_req     = cost_req;
    assign bus.cost_disp    = cost_disp;
    assign bus.busy         = busy;
    assign bus.best_cost    = best_cost;
    assign bus.best_disp    = best_disp;
    assign bus.result_valid = result_valid;
    assign bus.range_err    = range_err;

endmodule

// File: tb/tb_disparity_scan_ctrl.sv
// Scoreboard bench for disparity_scan_ctrl: a behavioural cost engine answers
// requests, expected requests and results are queued and checked on arrival.
module tb_disparity_scan_ctrl;

    localparam int COST_W = 18;
    localparam int DISP_W = 6;
    localparam logic [COST_W-1:0] CMAX = {COST_W{1'b1}};

    typedef struct {
        logic [COST_W-1:0] cost;
        logic [DISP_W-1:0] disp;
        logic              err;
    } res_t;

    logic clk;
    logic rst;

    disparity_scan_ctrl_if #(.COST_W(COST_W), .DISP_W(DISP_W)) ifc ();

    disparity_scan_ctrl #(.COST_W(COST_W), .DISP_W(DISP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [DISP_W-1:0] exp_req[$];
    res_t              exp_res[$];
    logic [COST_W-1:0] cost_tab[64];
    int                lat = 1;
    int                pend = 0;
    logic [DISP_W-1:0] pend_disp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_res(input logic [COST_W-1:0] c, input logic [DISP_W-1:0] d, input logic e);
        res_t r;
        r.cost = c;
        r.disp = d;
        r.err  = e;
        exp_res.push_back(r);
    endtask

    task automatic push_reqs(input int lo, input int hi);
        for (int d = lo; d <= hi; d++) exp_req.push_back(DISP_W'(d));
    endtask

    task automatic start_scan(input int lo, input int hi);
        ifc.disp_min = DISP_W'(lo);
        ifc.disp_max = DISP_W'(hi);
        ifc.start    = 1'b1;
        cyc();
        ifc.start    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ifc.busy && n < 300) begin
            cyc();
            n++;
        end
        chk("idle_timeout", ifc.busy, 0);
    endtask

    task automatic wait_req(input int d);
        int n = 0;
        while (!(ifc.cost_req && ifc.cost_disp == DISP_W'(d)) && n < 100) begin
            cyc();
            n++;
        end
        chk("req_timeout", ifc.cost_req, 1);
    endtask

    // Cost engine model and result scoreboard, both acting on the falling edge.
    initial begin
        ifc.cost_valid = 1'b0;
        ifc.cost_in    = '0;
        forever begin
            @(negedge clk);
            ifc.cost_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (ifc.busy) chk("disp_hold", ifc.cost_disp, pend_disp);
                    ifc.cost_valid = 1'b1;
                    ifc.cost_in    = cost_tab[pend_disp];
                end
            end
            if (ifc.cost_req) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", ifc.cost_req, 0);
                end else begin
                    chk("req_disp", ifc.cost_disp, exp_req.pop_front());
                end
                pend      = lat;
                pend_disp = ifc.cost_disp;
            end
            if (ifc.result_valid && ifc.result_ready) begin
                if (exp_res.size() == 0) begin
                    chk("res_unexpected", ifc.result_valid, 0);
                end else begin
                    res_t e;
                    e = exp_res.pop_front();
                    chk("best_cost", ifc.best_cost, e.cost);
                    chk("best_disp", ifc.best_disp, e.disp);
                    chk("range_err", ifc.range_err, e.err);
                end
            end
        end
    end

    initial begin
        int n;
        rst              = 1'b1;
        ifc.start        = 1'b0;
        ifc.disp_min     = '0;
        ifc.disp_max     = '0;
        ifc.abort        = 1'b0;
        ifc.result_ready = 1'b0;
        for (int i = 0; i < 64; i++) cost_tab[i] = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_cost_req", ifc.cost_req, 0);
        chk("rst_cost_disp", ifc.cost_disp, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_best_cost", ifc.best_cost, CMAX);
        chk("rst_best_disp", ifc.best_disp, 0);
        chk("rst_result_valid", ifc.result_valid, 0);
        chk("rst_range_err", ifc.range_err, 0);

        // 0..3 with a tie at 200: lower disparity wins, result after 9 edges.
        lat = 1;
        cost_tab[0] = 500; cost_tab[1] = 200; cost_tab[2] = 200; cost_tab[3] = 900;
        push_reqs(0, 3);
        push_res(200, 1, 0);
        ifc.result_ready = 1'b1;
        start_scan(0, 3);
        n = 1;
        while (!ifc.result_valid && n < 100) begin
            cyc();
            n++;
        end
        chk("latency_0_3", n, 9);
        wait_idle();
        cyc();

        // Single disparity carrying the largest cost.
        cost_tab[5] = CMAX;
        push_reqs(5, 5);
        push_res(CMAX, 5, 0);
        start_scan(5, 5);
        wait_idle();
        cyc();

        // Empty range: straight to DONE with no requests.
        push_res(CMAX, 10, 1);
        start_scan(10, 4);
        chk("empty_valid", ifc.result_valid, 1);
        chk("empty_no_req", ifc.cost_req, 0);
        wait_idle();
        cyc();

        // Top of the range, 3-cycle latency, back-pressure and ignored starts.
        lat = 3;
        ifc.result_ready = 1'b0;
        cost_tab[60] = 40; cost_tab[61] = 30; cost_tab[62] = 20; cost_tab[63] = 10;
        push_reqs(60, 63);
        push_res(10, 63, 0);
        start_scan(60, 63);
        for (int i = 0; i < 4; i++) cyc();
        start_scan(0, 1);
        n = 0;
        while (!ifc.result_valid && n < 100) begin
            cyc();
            n++;
        end
        chk("hi_valid", ifc.result_valid, 1);
        for (int i = 0; i < 5; i++) begin
            ifc.start = (i == 2);
            cyc();
            chk("hold_valid", ifc.result_valid, 1);
            chk("hold_disp", ifc.best_disp, 63);
            chk("hold_cost", ifc.best_cost, 10);
            chk("hold_busy", ifc.busy, 1);
        end
        ifc.result_ready = 1'b1;
        ifc.start        = 1'b1;
        cyc();
        ifc.start = 1'b0;
        chk("accept_valid", ifc.result_valid, 0);
        chk("accept_busy", ifc.busy, 0);
        cyc();
        chk("accept_no_restart", ifc.busy, 0);
        chk("no_wrap_req", ifc.cost_req, 0);

        // Abort while waiting on disparity 2 of 0..7.
        cost_tab[0] = 50; cost_tab[1] = 40; cost_tab[2] = 1;
        push_reqs(0, 2);
        start_scan(0, 7);
        wait_req(2);
        cyc();
        chk("abort_pre_busy", ifc.busy, 1);
        ifc.abort = 1'b1;
        cyc();
        ifc.abort = 1'b0;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_keep_cost", ifc.best_cost, 40);
        chk("abort_keep_disp", ifc.best_disp, 1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_no_result", ifc.result_valid, 0);
        end
        lat = 1;
        cost_tab[0] = 7; cost_tab[1] = 3;
        push_reqs(0, 1);
        push_res(3, 1, 0);
        start_scan(0, 1);
        wait_idle();
        cyc();

        // Reset mid-scan, then a stray cost_valid from the engine.
        lat = 3;
        cost_tab[0] = 77; cost_tab[1] = 88;
        push_reqs(0, 7);
        start_scan(0, 7);
        wait_req(1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_req.delete();
        chk("mid_rst_busy", ifc.busy, 0);
        chk("mid_rst_best_cost", ifc.best_cost, CMAX);
        chk("mid_rst_best_disp", ifc.best_disp, 0);
        chk("mid_rst_cost_disp", ifc.cost_disp, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stray_busy", ifc.busy, 0);
            chk("stray_req", ifc.cost_req, 0);
            chk("stray_valid", ifc.result_valid, 0);
        end
        chk("stray_best_cost", ifc.best_cost, CMAX);

        chk("req_left", exp_req.size(), 0);
        chk("res_left", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disparity_scan_ctrl.md
Name: disparity_scan_ctrl

Overview:
Sequencer for the stereo disparity search. On start it walks a disparity range and issues one cost request per disparity to the SAD cost engine. It tracks the running minimum cost and its disparity (argmin), then presents the winning disparity to the depth stage with a valid/ready handshake. This replaces the ad-hoc start/update minimum tracker with a clocked, self-sequencing controller.

Parameters:
COST_W, 18, width of matching cost
DISP_W, 6, width of disparity index
COST_MAX, all-ones of COST_W, cost reported when no disparity was scanned

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a scan; honoured only in IDLE
disp_min  in  DISP_W  first disparity of the range; latched on accepted start
disp_max  in  DISP_W  last disparity, inclusive; latched on accepted start
cost_req  out  1  one-cycle pulse requesting the cost for cost_disp
cost_disp  out  DISP_W  disparity being requested; stable from cost_req until cost_valid
cost_valid  in  1  cost engine returns cost_in for cost_disp
cost_in  in  COST_W  matching cost
abort  in  1  cancels the scan in progress
busy  out  1  high in REQ, WAIT and DONE
best_cost  out  COST_W  minimum cost found
best_disp  out  DISP_W  disparity of best_cost
result_valid  out  1  result available; held until accepted
result_ready  in  1  consumer accepts the result
range_err  out  1  qualifies result: disp_max < disp_min

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset values: state IDLE; cost_req 0; cost_disp 0; busy 0; best_cost COST_MAX; best_disp 0; result_valid 0; range_err 0; first-sample flag 1.
- IDLE:
  - start=1 latches disp_min/disp_max and sets cost_disp=disp_min.
  - If disp_max>=disp_min: set first flag, range_err=0, go REQ.
  - Otherwise: go DONE with best_cost=COST_MAX, best_disp=disp_min, range_err=1.
- REQ: cost_req=1 for exactly this one cycle; go WAIT.
- WAIT: hold until cost_valid=1.
  - On the cost_valid edge: if first flag, load best_cost/best_disp unconditionally and clear the flag.
  - Otherwise, update best only if cost_in < best_cost (strict). Ties keep the lower disparity.
  - If cost_disp==disp_max (latched), go DONE. Otherwise cost_disp+1 and go REQ.
  - No wrap-around: disp_max=2^DISP_W-1 terminates without incrementing.
- Timing:
  - Minimum 2 cycles per disparity. Scan of N disparities with 1-cycle cost latency takes 2N cycles from start to DONE entry.
  - result_valid rises the cycle after the final cost_valid.
- DONE:
  - result_valid=1; best_cost, best_disp and range_err held stable.
  - result_valid=1 with result_ready=1 completes the handshake, and the block returns to IDLE next cycle.
  - result_ready may be high in advance, giving zero extra wait.
- start outside IDLE is ignored, including in DONE.
- start and result_ready in the same DONE cycle: the result is accepted and start is ignored.
- cost_valid outside WAIT is ignored. cost_valid in the same cycle as the REQ pulse is ignored.
- abort in REQ or WAIT: return to IDLE next cycle with no result. best_cost/best_disp keep their last values; result_valid stays 0. abort in IDLE or DONE has no effect.
- rst mid-scan: all registers return to reset values on that edge. A late cost_valid afterwards is ignored.
- Arithmetic: unsigned compare on COST_W bits; disparity increment on DISP_W bits.

Test Plan:
- disp 0..3, costs 500,200,200,900, 1-cycle latency, result_ready=1 -> best_cost=200, best_disp=1 (tie keeps lower); result_valid at cycle 9 after start; cost_req pulses with cost_disp 0,1,2,3.
- disp 5..5, cost 0x3FFFF -> one request; best_cost=0x3FFFF, best_disp=5; range_err=0.
- disp_min=10, disp_max=4 -> no cost_req; result_valid next cycle+1 with best_cost=0x3FFFF, best_disp=10, range_err=1.
- disp 60..63, costs 40,30,20,10, cost latency 3 cycles, result_ready low 5 cycles -> best_disp=63, best_cost=10; result held stable 5 cycles; no cost_disp wrap; start pulses during scan ignored.
- abort during WAIT at disp 2 of 0..7 -> IDLE next cycle, result_valid never rises; a following scan of 0..1 with costs 7,3 -> best_disp=1, best_cost=3.
- rst asserted mid-scan, then a stray cost_valid -> all outputs at reset values and no state change.
